// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the two-bank ECG sample buffer sequencer.
// Contents: state_e (fill/wait FSM state), default address/data widths and the
// frame counter width.
package pingpong_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Bus bundle between the sample source / bank consumer and pingpong_buf_ctrl.
// Signals:
//   smp_valid, smp_data : ADC sample strobe and data
//   lc_done             : consumer finished its bank
//   fu_addra, fu_we,
//   dt_an               : fill-bank write port
//   switch              : bank select
//   frame_rdy, frame_cnt,
//   overrun, drop_cnt   : status
// Modports: master (sample source / consumer side), slave (the controller).
interface pingpong_buf_ctrl_if
  import pingpong_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic                   smp_valid;
  logic [DATA_W-1:0]      smp_data;
  logic                   lc_done;
  logic [ADDR_W-1:0]      fu_addra;
  logic                   fu_we;
  logic [DATA_W-1:0]      dt_an;
  logic                   switch;
  logic                   frame_rdy;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   overrun;
  logic [15:0]            drop_cnt;

  modport master (
    output smp_valid, smp_data, lc_done,
    input  fu_addra, fu_we, dt_an, switch, frame_rdy, frame_cnt, overrun, drop_cnt
  );

  modport slave (
    input  smp_valid, smp_data, lc_done,
    output fu_addra, fu_we, dt_an, switch, frame_rdy, frame_cnt, overrun, drop_cnt
  );

endinterface

// File: rtl/pingpong_addr_ctr.sv
// Fill-bank write address counter. Wraps from DEPTH-1 to 0 on increment.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force address to 0
//   inc      : advance address by one (wrapping)
//   addr     : current write address
//   tc       : terminal count, addr == DEPTH-1
module pingpong_addr_ctr #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q;

  assign addr = addr_q;
  assign tc   = (addr_q == LastAddr);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr_q <= '0;
    end else if (inc) begin
      addr_q <= tc ? '0 : addr_q + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank (ping-pong) ECG sample buffer sequencer. Writes the ADC stream into
// the fill bank, swaps banks when a frame is complete and the consumer has
// released the previous one, counts frames and flags dropped samples.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : pingpong_buf_ctrl_if.slave (sample in, lc_done in, write port
//              and status out); all outputs registered
// Build option: PINGPONG_DROP_CNT_EN enables the saturating drop counter;
// without it drop_cnt is tied to 0.
module pingpong_buf_ctrl
  import pingpong_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                 clk,
  input logic                 rst,
  pingpong_buf_ctrl_if.slave  bus
);

  state_e                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic                   fu_we_q, fu_we_d;
  logic [ADDR_W-1:0]      fu_addra_q, fu_addra_d;
  logic [DATA_W-1:0]      dt_an_q, dt_an_d;
  logic                   switch_q, switch_d;
  logic                   frame_rdy_q, frame_rdy_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;

  logic                   accept, drop, swap, addr_clr;
  logic [ADDR_W-1:0]      wr_addr;
  logic                   wr_tc;

  pingpong_addr_ctr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (addr_clr),
    .inc  (accept),
    .addr (wr_addr),
    .tc   (wr_tc)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    drop     = 1'b0;
    swap     = 1'b0;
    addr_clr = 1'b0;
    unique case (state_q)
      FILL: begin
        swap = last_wr_q && (!frame_rdy_q || bus.lc_done);
        if (last_wr_q && !swap) begin
          // Fill bank is full and cannot be handed over: a sample here would
          // overwrite address 0 of the completed frame, so it is dropped.
          state_d = WAIT;
          drop    = bus.smp_valid;
        end else begin
          accept = bus.smp_valid;
        end
      end
      WAIT: begin
        drop = bus.smp_valid;
        if (bus.lc_done) begin
          swap     = 1'b1;
          addr_clr = 1'b1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    last_wr_d   = accept && wr_tc;
    fu_we_d     = accept;
    fu_addra_d  = accept ? wr_addr : fu_addra_q;
    dt_an_d     = accept ? bus.smp_data : dt_an_q;
    switch_d    = switch_q ^ swap;
    // A swap hands a fresh frame to the consumer; otherwise lc_done releases it.
    frame_rdy_d = swap ? 1'b1 : (bus.lc_done ? 1'b0 : frame_rdy_q);
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(swap);
    overrun_d   = overrun_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      last_wr_q   <= 1'b0;
      fu_we_q     <= 1'b0;
      fu_addra_q  <= '0;
      dt_an_q     <= '0;
      switch_q    <= 1'b0;
      frame_rdy_q <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      fu_we_q     <= fu_we_d;
      fu_addra_q  <= fu_addra_d;
      dt_an_q     <= dt_an_d;
      switch_q    <= switch_d;
      frame_rdy_q <= frame_rdy_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.fu_we     = fu_we_q;
  assign bus.fu_addra  = fu_addra_q;
  assign bus.dt_an     = dt_an_q;
  assign bus.switch    = switch_q;
  assign bus.frame_rdy = frame_rdy_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed self-checking bench for pingpong_buf_ctrl with DEPTH=8.
module tb_pingpong_buf_ctrl;

  localparam int unsigned Depth = 8;
  localparam int unsigned AddrW = 3;
  localparam int unsigned DataW = 32;

`ifdef PINGPONG_DROP_CNT_EN
  localparam int unsigned ExpDrop3 = 3;
`else
  localparam int unsigned ExpDrop3 = 0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pingpong_buf_ctrl_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  pingpong_buf_ctrl #(
    .DEPTH  (Depth),
    .ADDR_W (AddrW),
    .DATA_W (DataW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int sw, input int rdy, input int cnt,
                              input int ovr, input int drp);
    check_eq({tag, ".switch"}, 32'(bus.switch), 32'(sw));
    check_eq({tag, ".frame_rdy"}, 32'(bus.frame_rdy), 32'(rdy));
    check_eq({tag, ".frame_cnt"}, 32'(bus.frame_cnt), 32'(cnt));
    check_eq({tag, ".overrun"}, 32'(bus.overrun), 32'(ovr));
    check_eq({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(drp));
  endtask

  task automatic send(input string tag, input logic [31:0] data, input int exp_addr);
    bus.smp_valid = 1'b1;
    bus.smp_data  = data;
    tick();
    bus.smp_valid = 1'b0;
    check_eq({tag, ".we"}, 32'(bus.fu_we), 32'd1);
    check_eq({tag, ".addr"}, 32'(bus.fu_addra), 32'(exp_addr));
    check_eq({tag, ".data"}, bus.dt_an, data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    bus.lc_done   = 1'b0;

    // Reset state.
    do_reset();
    check_eq("rst.we", 32'(bus.fu_we), 32'd0);
    check_eq("rst.addr", 32'(bus.fu_addra), 32'd0);
    check_eq("rst.data", bus.dt_an, 32'd0);
    check_status("rst", 0, 0, 0, 0, 0);

    // Frame 1: addresses 0..7, swap one cycle after the addr-7 write.
    for (int i = 0; i < 8; i++) send("f1", 32'h100 + 32'(i), i);
    check_eq("f1.sw_before", 32'(bus.switch), 32'd0);
    tick();
    check_eq("f1.we_idle", 32'(bus.fu_we), 32'd0);
    check_status("f1.swap", 1, 1, 1, 0, 0);

    // Frame 2 without lc_done, then 3 samples dropped in WAIT.
    for (int i = 0; i < 8; i++) send("f2", 32'h200 + 32'(i), i);
    tick();
    check_status("f2.wait", 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.smp_valid = 1'b1;
      bus.smp_data  = 32'hDEAD0000 + 32'(i);
      tick();
      check_eq("wait.we", 32'(bus.fu_we), 32'd0);
    end
    bus.smp_valid = 1'b0;
    check_status("wait.drop", 1, 1, 1, 1, ExpDrop3);
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done = 1'b0;
    check_status("wait.release", 0, 1, 2, 1, ExpDrop3);
    send("f3", 32'h300, 0);

    // lc_done coincident with last_wr while frame_rdy=1: direct swap, no drop.
    for (int i = 1; i < 8; i++) send("f3", 32'h300 + 32'(i), i);
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done = 1'b0;
    check_status("f3.swap", 1, 1, 3, 1, ExpDrop3);
    send("f4", 32'h400, 0);
    check_status("f4.after", 1, 1, 3, 1, ExpDrop3);

    // Continuous stream, lc_done the cycle after each swap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.lc_done = (i == 9 || i == 17) ? 1'b1 : 1'b0;
      send("strm", 32'h500 + 32'(i), i % 8);
      check_eq("strm.switch", 32'(bus.switch), (i >= 16) ? 32'd0 : (i >= 8) ? 32'd1 : 32'd0);
    end
    bus.lc_done = 1'b0;
    tick();
    check_status("strm.end", 0, 0, 2, 0, 0);
    send("strm.next", 32'h600, 4);

    // Reset mid-frame at addr 5, with a simultaneous sample.
    do_reset();
    for (int i = 0; i < 8; i++) send("r.f", 32'h700 + 32'(i), i);
    for (int i = 0; i < 5; i++) send("r.p", 32'h800 + 32'(i), i);
    bus.smp_valid = 1'b1;
    bus.smp_data  = 32'h900;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
    bus.smp_valid = 1'b0;
    check_eq("rmid.we", 32'(bus.fu_we), 32'd0);
    check_eq("rmid.addr", 32'(bus.fu_addra), 32'd0);
    check_eq("rmid.data", bus.dt_an, 32'd0);
    check_status("rmid", 0, 0, 0, 0, 0);
    send("rmid.next", 32'hA00, 0);

    // lc_done with frame_rdy=0 is ignored.
    tick();
    bus.lc_done = 1'b1;
    tick();
    bus.lc_done = 1'b0;
    check_eq("ign.we", 32'(bus.fu_we), 32'd0);
    check_status("ign", 0, 0, 0, 0, 0);
    send("ign.next", 32'hA01, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pingpong_buf_ctrl.md
Name: pingpong_buf_ctrl

Overview:
- Sequencer for the two-bank ECG sample buffer.
- Takes the ADC sample stream and generates the fill-side write address, write strobe and write data.
- Drives the bank-select `switch` that routes one bank to the filler and the other to the consumer (`lc` side).
- Swaps banks only when a frame is complete and the consumer has released the previous frame. Counts frames and flags overruns.

Parameters:
- DEPTH, 4096, samples per frame (bank size); power of two, ≤ 2^ADDR_W.
- ADDR_W, 12, bank address width.
- DATA_W, 32, sample width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- smp_valid  in  1  one-cycle strobe: smp_data holds a new sample.
- smp_data  in  DATA_W  ADC sample.
- lc_done  in  1  one-cycle pulse: consumer finished the frame in its bank.
- fu_addra  out  ADDR_W  fill-bank write address.
- fu_we  out  1  fill-bank write strobe.
- dt_an  out  DATA_W  fill-bank write data.
- switch  out  1  bank select; 0 = bank1 read / bank2 fill, 1 = swapped.
- frame_rdy  out  1  level; the read bank holds a complete, unconsumed frame.
- frame_cnt  out  16  frames completed, wraps at 0xFFFF→0.
- overrun  out  1  sticky; a sample was dropped.
- drop_cnt  out  16  dropped-sample count (see optional feature).

Behaviour:
- Reset values: all outputs 0; wr_addr=0; state FILL. Reset mid-frame discards the partial frame; the next accepted sample goes to address 0.
- All outputs are registered.
- Write path: a sample accepted at edge N drives fu_we=1, fu_addra=wr_addr and dt_an=smp_data during cycle N..N+1. fu_we is a single-cycle pulse per sample.
- Address counter:
  - wr_addr increments per accepted sample.
  - After DEPTH-1 it wraps to 0 on the same edge.
- State FILL:
  - Accept every smp_valid.
  - On accepting address DEPTH-1, set last_wr for exactly one cycle.
- Swap decision (cycle with last_wr=1):
  - If rd_pending=0, or lc_done=1 this cycle: toggle switch at the next edge, set frame_rdy=1, increment frame_cnt, stay in FILL.
  - Otherwise: go to WAIT.
  - The switch toggle is therefore one cycle after the last fu_we, so the final write lands in the old fill bank.
  - There is no bubble: a smp_valid arriving in the toggle cycle is written to address 0 of the new fill bank.
- State WAIT (fill bank full, consumer busy):
  - smp_valid is dropped: fu_we stays 0, overrun is set (sticky until rst), drop_cnt increments.
  - On lc_done: toggle switch at the next edge, frame_rdy stays 1, increment frame_cnt, return to FILL with wr_addr=0.
  - A sample arriving in the same cycle as lc_done is still dropped.
- frame_rdy (= rd_pending):
  - Set on swap; cleared on lc_done when no swap occurs in the same cycle.
  - lc_done with frame_rdy=0 is ignored.
- smp_valid and rst in the same cycle: rst wins.

Optional Feature:
- Macro PINGPONG_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter saturating at 0xFFFF, cleared only by rst.
- Undefined: the counter logic is removed and drop_cnt is tied to 0. overrun behaviour is unchanged.

Decomposition:
- Package pingpong_pkg:
  - state typedef {FILL, WAIT}.
  - DEF_ADDR_W=12, DEF_DATA_W=32, FRAME_CNT_W=16.
- One sub-module, pingpong_addr_ctr: wr_addr counter with clear and increment inputs and a terminal-count output (addr==DEPTH-1). The FSM, switch, flags and counters stay in the top module.

Test Plan (DEPTH=8):
- rst, then 8 smp_valid with data 0x100..0x107 → fu_we pulses at addr 0..7 with dt_an matching, one cycle after each strobe; switch 0→1 one cycle after the addr-7 write; frame_rdy=1; frame_cnt=1.
- Second frame filled without lc_done, then 3 more samples → state WAIT, fu_we stays 0, overrun=1, drop_cnt=3. Then pulse lc_done → switch 1→0 next edge, frame_rdy=1, frame_cnt=2, next sample written at addr 0.
- lc_done in the same cycle as last_wr with frame_rdy=1 → swap with no WAIT entry and no drop; frame_rdy stays 1.
- smp_valid every cycle for 20 cycles with lc_done pulsed after each swap → addresses 7,0 on consecutive cycles, zero drops, frame_cnt=2 and wr_addr=4 at the end.
- rst asserted at addr 5 → next cycle all outputs 0, switch=0; next sample written at addr 0.
- lc_done with frame_rdy=0 → no output changes. Rebuilt without PINGPONG_DROP_CNT_EN, the overrun scenario gives drop_cnt=0 and overrun=1.
